vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM among three requesters: VGA scan-out fetch (video), CPU bus, and UART loader DMA.
- Sits between the soc's CPU, VGA timing/fetch logic and UART loader on one side, and the block-RAM primitive on the other.
- Video has priority with a bounded streak so the others cannot starve. CPU and DMA share the remaining slots round-robin.
- Issues at most one memory access per clock and returns read data tagged to the issuing requester.

---
 rtl/vram_arbiter_pkg.sv | 32 +++
 rtl/vram_rtag_pipe.sv | 54 +++++
 rtl/vram_arbiter.sv | 153 +++++++++++++++
 tb/tb_vram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the video RAM arbiter.
package vram_arbiter_pkg;

   localparam int VRAM_ADDR_W        = 16;
   localparam int VRAM_DATA_W        = 8;
   localparam int DEF_MAX_VID_STREAK = 3;
   localparam int DEF_RD_LAT         = 1;

   // Requester identity, also used as the read-return tag.
   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_VID  = 2'd1,
      REQ_CPU  = 2'd2,
      REQ_DMA  = 2'd3
   } reqId_t;

   // One RAM access as presented on the mem_* port.
   typedef struct packed {
      logic                   en;
      logic                   we;
      logic [VRAM_ADDR_W-1:0] addr;
      logic [VRAM_DATA_W-1:0] wdata;
   } memCmd_t;

   localparam memCmd_t MEM_CMD_IDLE = '{
      en:    1'b0,
      we:    1'b0,
      addr:  {VRAM_ADDR_W{1'b0}},
      wdata: {VRAM_DATA_W{1'b0}}
   };

endpackage

// File: rtl/vram_rtag_pipe.sv
// Read-return tag pipe: carries {valid, requester} alongside the RAM read
// latency and decodes the emerging tag into per-requester rvalid pulses.
module vram_rtag_pipe
   import vram_arbiter_pkg::*;
#(
   parameter int STAGES = DEF_RD_LAT + 1
) (
   input  logic   clk,
   input  logic   clear,
   input  logic   inValid,
   input  reqId_t inId,
   output logic   vidValid,
   output logic   cpuValid,
   output logic   dmaValid
);

   logic [STAGES-1:0] valid_r;
   reqId_t            id_r [STAGES];

   // Shift tags toward the return point; clear drops every in-flight read.
   always_ff @(posedge clk) begin
      if (clear) begin
         valid_r <= {STAGES{1'b0}};
         for (int i = 0; i < STAGES; i++) begin
            id_r[i] <= REQ_NONE;
         end
      end else begin
         valid_r[0] <= inValid;
         id_r[0]    <= inId;
         for (int i = 1; i < STAGES; i++) begin
            valid_r[i] <= valid_r[i-1];
            id_r[i]    <= id_r[i-1];
         end
      end
   end

   // Decode the last stage (a register) into one pulse per requester.
   always_comb begin
      vidValid = 1'b0;
      cpuValid = 1'b0;
      dmaValid = 1'b0;
      if (valid_r[STAGES-1]) begin
         case (id_r[STAGES-1])
            REQ_VID: vidValid = 1'b1;
            REQ_CPU: cpuValid = 1'b1;
            REQ_DMA: dmaValid = 1'b1;
            default: vidValid = 1'b0;
         endcase
      end else begin
         vidValid = 1'b0;
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetch has priority with a bounded
// streak, CPU and UART-loader DMA share the remaining slots round-robin.
// The command register uses the package-wide widths; ADDR_W/DATA_W must
// not exceed VRAM_ADDR_W/VRAM_DATA_W.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W         = VRAM_ADDR_W,
   parameter int DATA_W         = VRAM_DATA_W,
   parameter int MAX_VID_STREAK = DEF_MAX_VID_STREAK,
   parameter int RD_LAT         = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                STREAK_W   = $clog2(MAX_VID_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

   reqId_t              grant_s;
   reqId_t              rrNext_r;
   logic [STREAK_W-1:0] vidStreak_r;
   logic                otherReq_s;
   logic                issueRead_s;
   memCmd_t             cmdNext_s;
   memCmd_t             cmd_r;

   // Pick this cycle's winner: video below its streak limit (or alone),
   // otherwise the round-robin CPU/DMA winner; nothing while in reset.
   always_comb begin
      grant_s    = REQ_NONE;
      otherReq_s = cpu_req | dma_req;
      if (reset) begin
         grant_s = REQ_NONE;
      end else if (vid_req && ((vidStreak_r < STREAK_MAX) || !otherReq_s)) begin
         grant_s = REQ_VID;
      end else if (cpu_req && dma_req) begin
         grant_s = rrNext_r;
      end else if (cpu_req) begin
         grant_s = REQ_CPU;
      end else if (dma_req) begin
         grant_s = REQ_DMA;
      end else begin
         grant_s = REQ_NONE;
      end
   end

   // Build the RAM command of the granted requester; video always reads.
   always_comb begin
      cmdNext_s = MEM_CMD_IDLE;
      case (grant_s)
         REQ_VID: begin
            cmdNext_s.en   = 1'b1;
            cmdNext_s.we   = 1'b0;
            cmdNext_s.addr = VRAM_ADDR_W'(vid_addr);
         end
         REQ_CPU: begin
            cmdNext_s.en    = 1'b1;
            cmdNext_s.we    = cpu_we;
            cmdNext_s.addr  = VRAM_ADDR_W'(cpu_addr);
            cmdNext_s.wdata = VRAM_DATA_W'(cpu_wdata);
         end
         REQ_DMA: begin
            cmdNext_s.en    = 1'b1;
            cmdNext_s.we    = dma_we;
            cmdNext_s.addr  = VRAM_ADDR_W'(dma_addr);
            cmdNext_s.wdata = VRAM_DATA_W'(dma_wdata);
         end
         default: cmdNext_s = MEM_CMD_IDLE;
      endcase
   end

   assign issueRead_s = cmdNext_s.en & ~cmdNext_s.we;

   // Register the RAM command and update the video streak and CPU/DMA pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_r       <= MEM_CMD_IDLE;
         vidStreak_r <= {STREAK_W{1'b0}};
         rrNext_r    <= REQ_CPU;
      end else begin
         cmd_r <= cmdNext_s;
         case (grant_s)
            REQ_VID: begin
               if (vidStreak_r != STREAK_MAX) begin
                  vidStreak_r <= vidStreak_r + STREAK_W'(1'b1);
               end else begin
                  vidStreak_r <= STREAK_MAX;
               end
            end
            REQ_CPU: begin
               vidStreak_r <= {STREAK_W{1'b0}};
               rrNext_r    <= REQ_DMA;
            end
            REQ_DMA: begin
               vidStreak_r <= {STREAK_W{1'b0}};
               rrNext_r    <= REQ_CPU;
            end
            default: vidStreak_r <= {STREAK_W{1'b0}};
         endcase
      end
   end

   vram_rtag_pipe #(
      .STAGES (RD_LAT + 1)
   ) u_rtagPipe (
      .clk      (clk),
      .clear    (reset),
      .inValid  (issueRead_s),
      .inId     (grant_s),
      .vidValid (vid_rvalid),
      .cpuValid (cpu_rvalid),
      .dmaValid (dma_rvalid)
   );

   assign vid_ack   = (grant_s == REQ_VID);
   assign cpu_ack   = (grant_s == REQ_CPU);
   assign dma_ack   = (grant_s == REQ_DMA);

   assign mem_en    = cmd_r.en;
   assign mem_we    = cmd_r.we;
   assign mem_addr  = ADDR_W'(cmd_r.addr);
   assign mem_wdata = DATA_W'(cmd_r.wdata);

   assign vid_rdata = mem_rdata;
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes hand-derived grants,
// RAM commands and read returns; a negedge monitor pops and compares.
module tb_vram_arbiter;
   import vram_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0, cpu_req = 1'b0, dma_req = 1'b0;
   logic        cpu_we = 1'b0, dma_we = 1'b0;
   logic [15:0] vid_addr = 16'h0, cpu_addr = 16'h0, dma_addr = 16'h0;
   logic [7:0]  cpu_wdata = 8'h0, dma_wdata = 8'h0;
   logic        vid_ack, cpu_ack, dma_ack;
   logic        vid_rvalid, cpu_rvalid, dma_rvalid;
   logic [7:0]  vid_rdata, cpu_rdata, dma_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Behavioural single-port RAM with one cycle read latency plus a preload port.
   logic [7:0]  ram [0:65535];
   logic [7:0]  ramQ = 8'h00;
   logic        preWe = 1'b0;
   logic [15:0] preAddr = 16'h0;
   logic [7:0]  preData = 8'h0;
   always @(posedge clk) begin
      if (preWe) ram[preAddr] <= preData;
      else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ramQ <= ram[mem_addr];
      end
   end
   assign mem_rdata = ramQ;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic we; logic [15:0] addr; logic [7:0] wdata; } memExp_t;
   typedef struct { int cyc; reqId_t id; logic [7:0] data; } rdExp_t;
   reqId_t  ackQ [$];
   memExp_t memQ [$];
   rdExp_t  rdQ  [$];
   logic [7:0] golden [0:65535];

   int nVec = 0;
   int nErr = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents ack, mem_en or rvalid.
   always @(negedge clk) begin : monitor
      int      nAck, nRv;
      reqId_t  ackId, rvId, eId;
      logic [7:0] rvData;
      memExp_t m;
      rdExp_t  r;
      nAck = int'(vid_ack) + int'(cpu_ack) + int'(dma_ack);
      if (nAck > 1) check("ack_onehot", nAck, 1);
      if (nAck != 0) begin
         ackId = vid_ack ? REQ_VID : (cpu_ack ? REQ_CPU : REQ_DMA);
         if (ackQ.size() == 0) check("ack_unexpected", ackId, REQ_NONE);
         else begin
            eId = ackQ.pop_front();
            check("ack_id", ackId, eId);
         end
      end
      if (mem_en) begin
         if (memQ.size() == 0) check("mem_unexpected", mem_en, 1'b0);
         else begin
            m = memQ.pop_front();
            check("mem_cycle", cyc, m.cyc);
            check("mem_cmd", {mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)},
                             {m.we, m.addr, (m.we ? m.wdata : 8'h00)});
         end
      end
      nRv = int'(vid_rvalid) + int'(cpu_rvalid) + int'(dma_rvalid);
      if (nRv > 1) check("rvalid_onehot", nRv, 1);
      if (nRv != 0) begin
         rvId   = vid_rvalid ? REQ_VID : (cpu_rvalid ? REQ_CPU : REQ_DMA);
         rvData = vid_rvalid ? vid_rdata : (cpu_rvalid ? cpu_rdata : dma_rdata);
         if (rdQ.size() == 0) check("rvalid_unexpected", rvId, REQ_NONE);
         else begin
            r = rdQ.pop_front();
            check("rd_cycle", cyc, r.cyc);
            check("rd_id", rvId, r.id);
            check("rd_data", rvData, r.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record the expected ack now, mem command next cycle, read return two cycles on.
   task automatic pushGrant(input reqId_t id, input bit expectReturn);
      memExp_t m;
      rdExp_t  r;
      ackQ.push_back(id);
      m.cyc = cyc + 1;
      case (id)
         REQ_VID: begin m.we = 1'b0;   m.addr = vid_addr; m.wdata = 8'h00;     end
         REQ_CPU: begin m.we = cpu_we; m.addr = cpu_addr; m.wdata = cpu_wdata; end
         default: begin m.we = dma_we; m.addr = dma_addr; m.wdata = dma_wdata; end
      endcase
      memQ.push_back(m);
      if (m.we) golden[m.addr] = m.wdata;
      else if (expectReturn) begin
         r.cyc = cyc + 2; r.id = id; r.data = golden[m.addr];
         rdQ.push_back(r);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      preWe = 1'b1; preAddr = a; preData = d; golden[a] = d;
      tick();
      preWe = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
   endtask

   task automatic dropAll();
      vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      repeat (4) tick();
   endtask

   reqId_t seqVC  [8]  = '{REQ_VID, REQ_VID, REQ_VID, REQ_CPU, REQ_VID, REQ_VID, REQ_VID, REQ_CPU};
   reqId_t seqCD  [6]  = '{REQ_CPU, REQ_DMA, REQ_CPU, REQ_DMA, REQ_CPU, REQ_DMA};
   reqId_t seqAll [12] = '{REQ_VID, REQ_VID, REQ_VID, REQ_CPU, REQ_VID, REQ_VID,
                           REQ_VID, REQ_DMA, REQ_VID, REQ_VID, REQ_VID, REQ_CPU};

   initial begin
      #1;
      tick();
      preload(16'h0040, 8'h77);
      preload(16'h2000, 8'h3C);
      preload(16'h0100, 8'h11);

      // Reset state with every request asserted: no ack, idle RAM port.
      vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
      @(negedge clk);
      check("rst_acks", {vid_ack, cpu_ack, dma_ack}, 3'b000);
      check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 26'h0);
      check("rst_rvalid", {vid_rvalid, cpu_rvalid, dma_rvalid}, 3'b000);
      tick();
      vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      reset = 1'b0;
      tick();

      // Lone CPU write: ack now, write command next cycle, no return.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
      pushGrant(REQ_CPU, 1'b1);
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      repeat (3) tick();

      // Lone CPU read of preloaded 0x0040 returns 0x77 two cycles after ack.
      cpu_req = 1'b1; cpu_addr = 16'h0040;
      pushGrant(REQ_CPU, 1'b1);
      tick();
      cpu_req = 1'b0;
      repeat (3) tick();

      // Video and CPU held from reset: V,V,V,C repeating.
      vid_addr = 16'h2000; cpu_addr = 16'h0040; cpu_we = 1'b0;
      vid_req = 1'b1; cpu_req = 1'b1;
      doReset();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin pushGrant(seqVC[i], 1'b1); tick(); end
      dropAll();

      // CPU read and DMA write held: C,D alternating, RAM busy every cycle.
      dma_addr = 16'h0100; dma_we = 1'b1; dma_wdata = 8'hA5;
      cpu_req = 1'b1; dma_req = 1'b1;
      doReset();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin pushGrant(seqCD[i], 1'b1); tick(); end
      dropAll();

      // All three held, DMA now reading back 0xA5.
      dma_we = 1'b0;
      vid_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
      doReset();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin pushGrant(seqAll[i], 1'b1); tick(); end
      dropAll();

      // Reset right after a CPU read ack discards its return.
      doReset();
      reset = 1'b0;
      cpu_req = 1'b1;
      pushGrant(REQ_CPU, 1'b0);
      tick();
      reset = 1'b1; dma_req = 1'b1;
      tick();
      reset = 1'b0;
      pushGrant(REQ_CPU, 1'b1);
      @(negedge clk);
      check("post_rst_mem_en", mem_en, 1'b0);
      check("post_rst_cpu_rvalid", cpu_rvalid, 1'b0);
      tick();
      pushGrant(REQ_DMA, 1'b1);
      tick();
      dropAll();

      check("ackQ_drained", ackQ.size(), 0);
      check("memQ_drained", memQ.size(), 0);
      check("rdQ_drained", rdQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
